// File: rtl/mcs4_rom_bridge.sv
// mcs4_rom_bridge: i4001-style ROM fetch and per-chip I/O port stage on the MCS-4 bus
module mcs4_rom_bridge #(
  parameter int NPORT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sync_n,
  input  logic [3:0]         i_data,
  output logic [3:0]         o_data,
  output logic               o_data_oe,
  input  logic               i_cm_rom_n,
  output logic [11:0]        o_mem_addr,
  output logic               o_mem_rd,
  input  logic [7:0]         i_mem_data,
  input  logic [4*NPORT-1:0] i_io,
  output logic [4*NPORT-1:0] o_io
);
  typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} state_t;
  state_t r_state, w_next;
  logic [7:0] r_adr, r_byte;
  logic [3:0] r_opr, r_opa, r_src_chip, r_data_o, w_rd;
  logic [4*NPORT-1:0] r_io_o;
  logic r_sel, r_io_op, r_data_oe, w_x2_end, w_rdr, w_wrr;
  always_comb begin
    w_next = !i_sync_n ? A1 : r_state == IDLE ? IDLE : r_state == X3 ? A1 : state_t'(r_state + 4'd1);
    w_x2_end = r_state == X2 && i_sync_n;
    w_rdr = r_io_op && r_opa == 4'hA;
    w_wrr = w_x2_end && r_io_op && r_opa == 4'h2;
    w_rd = '0;
    for (int k = 0; k < NPORT; k++)
      if (r_src_chip == k[3:0]) w_rd = i_io[4*k +: 4];
    o_mem_rd = r_state == A3;
    o_mem_addr = o_mem_rd ? {i_data, r_adr} : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_adr <= '0;
      r_byte <= '0;
      r_sel <= 1'b0;
      r_opr <= '0;
      r_opa <= '0;
      r_io_op <= 1'b0;
      r_src_chip <= '0;
      r_io_o <= '0;
      r_data_o <= '0;
      r_data_oe <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == A1) r_adr[3:0] <= i_data;
      if (r_state == A2) r_adr[7:4] <= i_data;
      if (r_state == A3) begin
        r_byte <= i_mem_data;
        r_sel <= !i_cm_rom_n;
      end
      if (r_state == M1) r_opr <= r_sel ? r_byte[7:4] : i_data;
      if (r_state == M2) r_opa <= r_sel ? r_byte[3:0] : i_data;
      // io_op lives only from M2 end to X3 end; any resync drops it
      r_io_op <= (r_state == M2 && i_sync_n) ? (!i_cm_rom_n && r_opr == 4'hE) :
                 (r_state == X3 || !i_sync_n) ? 1'b0 : r_io_op;
      if (w_x2_end && !i_cm_rom_n && !r_io_op) r_src_chip <= i_data;
      for (int k = 0; k < NPORT; k++)
        if (w_wrr && r_src_chip == k[3:0]) r_io_o[4*k +: 4] <= i_data;
      r_data_oe <= w_next == M1 ? !i_cm_rom_n : w_next == M2 ? r_sel : (w_next == X2 && w_rdr);
      r_data_o <= (w_next == M1 && !i_cm_rom_n) ? i_mem_data[7:4] :
                  (w_next == M2 && r_sel) ? r_byte[3:0] :
                  (w_next == X2 && w_rdr) ? w_rd : 4'h0;
    end
  end
  assign o_data = r_data_o;
  assign o_data_oe = r_data_oe;
  assign o_io = r_io_o;
endmodule
